// File: rtl/legv8_control_unit.sv
// legv8_control_unit
// Multi-cycle control unit for the LEGv8 datapath. It decodes the current
// instruction word and the datapath status bus into the 30-bit control word
// and the 64-bit constant. Single-state instructions finish in EXEC; LDUR adds
// LOAD2, where memory read data is valid, and BL adds BL2, which takes the branch.
//
// Control word layout, MSB to LSB:
//   {EN_PC, EN_Mem, EN_ALU, PCsel, Bsel, SL, WM, WR, PS[1:0], FS[4:0],
//    SB[4:0], SA[4:0], DA[4:0]}
//
// Build option: define CU_ILLEGAL_TRAP_EN to send any unrecognised opcode to
// HALT. When it is left undefined, such an opcode is a NOP that only advances
// the PC.

module legv8_control_unit #(
  parameter int ISA_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ISA_W-1:0] instruction,
  input  logic [4:0]       status,
  output logic [29:0]      control_word,
  output logic [63:0]      constant,
  output logic             halted
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_EXEC  = 3'd1,
    ST_LOAD2 = 3'd2,
    ST_BL2   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef enum logic [4:0] {
    C_ADD, C_ADDS, C_SUB, C_SUBS, C_AND, C_ORR, C_EOR,
    C_ADDI, C_SUBI, C_ANDI, C_ORRI, C_EORI,
    C_LSL, C_LSR, C_MOVZ,
    C_LDUR, C_STUR,
    C_B, C_BL, C_BR, C_CBZ, C_CBNZ, C_BCOND,
    C_HALT, C_ILLEGAL
  } iclass_t;

  // ALU function codes: {op[2:0], invert_b, carry_in}
  localparam logic [4:0] FS_AND  = 5'b00000;
  localparam logic [4:0] FS_OR   = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_SUB  = 5'b01011;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_LSL  = 5'b10000;
  localparam logic [4:0] FS_LSR  = 5'b10100;
  localparam logic [4:0] FS_PASS = 5'b11000;

  // PC-select codes
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_ABUS = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  // Opcode classification; the all-zero word is reserved for HALT.
  function automatic iclass_t classify(input logic [31:0] w);
    iclass_t c;
    if (w == 32'h0000_0000)             c = C_HALT;
    else if (w[31:21] == 11'b10001011000) c = C_ADD;
    else if (w[31:21] == 11'b10101011000) c = C_ADDS;
    else if (w[31:21] == 11'b11001011000) c = C_SUB;
    else if (w[31:21] == 11'b11101011000) c = C_SUBS;
    else if (w[31:21] == 11'b10001010000) c = C_AND;
    else if (w[31:21] == 11'b10101010000) c = C_ORR;
    else if (w[31:21] == 11'b11001010000) c = C_EOR;
    else if (w[31:21] == 11'b11010011011) c = C_LSL;
    else if (w[31:21] == 11'b11010011010) c = C_LSR;
    else if (w[31:21] == 11'b11010110000) c = C_BR;
    else if (w[31:21] == 11'b11111000010) c = C_LDUR;
    else if (w[31:21] == 11'b11111000000) c = C_STUR;
    else if (w[31:22] == 10'b1001000100)  c = C_ADDI;
    else if (w[31:22] == 10'b1101000100)  c = C_SUBI;
    else if (w[31:22] == 10'b1001001000)  c = C_ANDI;
    else if (w[31:22] == 10'b1011001000)  c = C_ORRI;
    else if (w[31:22] == 10'b1101001000)  c = C_EORI;
    else if (w[31:23] == 9'b110100101)    c = C_MOVZ;
    else if (w[31:24] == 8'b10110100)     c = C_CBZ;
    else if (w[31:24] == 8'b10110101)     c = C_CBNZ;
    else if (w[31:24] == 8'b01010100)     c = C_BCOND;
    else if (w[31:26] == 6'b000101)       c = C_B;
    else if (w[31:26] == 6'b100101)       c = C_BL;
    else                                  c = C_ILLEGAL;
    return c;
  endfunction

  // ALU function for the register and immediate arithmetic/logic classes.
  function automatic logic [4:0] alu_fs(input iclass_t c);
    logic [4:0] f;
    case (c)
      C_ADD, C_ADDS, C_ADDI: f = FS_ADD;
      C_SUB, C_SUBS, C_SUBI: f = FS_SUB;
      C_AND, C_ANDI:         f = FS_AND;
      C_ORR, C_ORRI:         f = FS_OR;
      C_EOR, C_EORI:         f = FS_XOR;
      default:               f = 5'b00000;
    endcase
    return f;
  endfunction

  // Signed 9-bit load/store offset.
  function automatic logic [63:0] sext_imm9(input logic [8:0] v);
    return {{55{v[8]}}, v};
  endfunction

  // Signed 26-bit word offset for B/BL, scaled to bytes.
  function automatic logic [63:0] br_off26(input logic [25:0] v);
    return {{36{v[25]}}, v, 2'b00};
  endfunction

  // Signed 19-bit word offset for CBZ/CBNZ/B.cond, scaled to bytes.
  function automatic logic [63:0] br_off19(input logic [18:0] v);
    return {{43{v[18]}}, v, 2'b00};
  endfunction

  // MOVZ immediate placed in the 16-bit lane selected by hw.
  function automatic logic [63:0] movz_imm(input logic [15:0] imm, input logic [1:0] hw);
    logic [63:0] k;
    case (hw)
      2'd0:    k = {48'h0, imm};
      2'd1:    k = {32'h0, imm, 16'h0};
      2'd2:    k = {16'h0, imm, 32'h0};
      2'd3:    k = {imm, 48'h0};
      default: k = 64'h0;
    endcase
    return k;
  endfunction

  // ARM condition evaluation on registered flags {V,C,N,Z}.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic v, c, n, z, r;
    v = flags[3];
    c = flags[2];
    n = flags[1];
    z = flags[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~(c & ~z);
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = ~(~z & (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  state_t           state;
  state_t           next_state;
  logic [ISA_W-1:0] ir;
  logic [31:0]      dec_word;
  iclass_t          cls;

  logic       en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr;
  logic [1:0] ps;
  logic [4:0] fs, sb, sa, da;
  logic [63:0] k;

  // EXEC decodes the live ROM word; the second states decode the latched copy.
  assign dec_word = (state == ST_EXEC) ? instruction : ir;
  assign cls      = classify(dec_word);

  // State register and instruction latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RST;
      ir    <= {ISA_W{1'b0}};
    end else begin
      state <= next_state;
      if (state == ST_EXEC) begin
        ir <= instruction;
      end else begin
        ir <= ir;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = ST_RST;
    case (state)
      ST_RST:   next_state = ST_EXEC;
      ST_EXEC: begin
        case (cls)
          C_LDUR:    next_state = ST_LOAD2;
          C_BL:      next_state = ST_BL2;
          C_HALT:    next_state = ST_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
          C_ILLEGAL: next_state = ST_HALT;
`else
          C_ILLEGAL: next_state = ST_EXEC;
`endif
          default:   next_state = ST_EXEC;
        endcase
      end
      ST_LOAD2: next_state = ST_EXEC;
      ST_BL2:   next_state = ST_EXEC;
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_RST;
    endcase
  end

  // Control fields from state and decoded word; unused fields stay 0.
  always_comb begin
    en_pc  = 1'b0;
    en_mem = 1'b0;
    en_alu = 1'b0;
    pcsel  = 1'b0;
    bsel   = 1'b0;
    sl     = 1'b0;
    wm     = 1'b0;
    wr     = 1'b0;
    ps     = PS_HOLD;
    fs     = 5'b00000;
    sb     = 5'b00000;
    sa     = 5'b00000;
    da     = 5'b00000;
    k      = 64'h0;
    halted = 1'b0;
    case (state)
      ST_EXEC: begin
        case (cls)
          C_ADD, C_ADDS, C_SUB, C_SUBS, C_AND, C_ORR, C_EOR: begin
            sa     = dec_word[9:5];
            sb     = dec_word[20:16];
            da     = dec_word[4:0];
            fs     = alu_fs(cls);
            sl     = ((cls == C_ADDS) || (cls == C_SUBS)) ? 1'b1 : 1'b0;
            en_alu = 1'b1;
            wr     = 1'b1;
            ps     = PS_INC;
          end
          C_ADDI, C_SUBI, C_ANDI, C_ORRI, C_EORI: begin
            sa     = dec_word[9:5];
            da     = dec_word[4:0];
            fs     = alu_fs(cls);
            bsel   = 1'b1;
            k      = {52'h0, dec_word[21:10]};
            en_alu = 1'b1;
            wr     = 1'b1;
            ps     = PS_INC;
          end
          C_LSL, C_LSR: begin
            sa     = dec_word[9:5];
            da     = dec_word[4:0];
            fs     = (cls == C_LSL) ? FS_LSL : FS_LSR;
            bsel   = 1'b1;
            k      = {58'h0, dec_word[15:10]};
            en_alu = 1'b1;
            wr     = 1'b1;
            ps     = PS_INC;
          end
          C_MOVZ: begin
            da     = dec_word[4:0];
            fs     = FS_PASS;
            bsel   = 1'b1;
            k      = movz_imm(dec_word[20:5], dec_word[22:21]);
            en_alu = 1'b1;
            wr     = 1'b1;
            ps     = PS_INC;
          end
          C_LDUR: begin
            // Address phase only: the PC holds until LOAD2 writes Rt.
            sa   = dec_word[9:5];
            fs   = FS_ADD;
            bsel = 1'b1;
            k    = sext_imm9(dec_word[20:12]);
            ps   = PS_HOLD;
          end
          C_STUR: begin
            sa   = dec_word[9:5];
            sb   = dec_word[4:0];
            fs   = FS_ADD;
            bsel = 1'b1;
            k    = sext_imm9(dec_word[20:12]);
            wm   = 1'b1;
            ps   = PS_INC;
          end
          C_B: begin
            k  = br_off26(dec_word[25:0]);
            ps = PS_REL;
          end
          C_BL: begin
            // Link phase: X30 takes the current PC before BL2 redirects it.
            en_pc = 1'b1;
            wr    = 1'b1;
            da    = 5'd30;
            ps    = PS_HOLD;
          end
          C_BR: begin
            sa = dec_word[9:5];
            ps = PS_ABUS;
          end
          C_CBZ, C_CBNZ: begin
            sb = dec_word[4:0];
            fs = FS_PASS;
            k  = br_off19(dec_word[23:5]);
            ps = (status[0] == ((cls == C_CBZ) ? 1'b1 : 1'b0)) ? PS_REL : PS_INC;
          end
          C_BCOND: begin
            k  = br_off19(dec_word[23:5]);
            ps = cond_holds(dec_word[3:0], status[4:1]) ? PS_REL : PS_INC;
          end
          C_HALT: begin
            ps = PS_HOLD;
          end
          C_ILLEGAL: begin
`ifdef CU_ILLEGAL_TRAP_EN
            ps = PS_HOLD;
`else
            ps = PS_INC;
`endif
          end
          default: begin
            ps = PS_HOLD;
          end
        endcase
      end
      ST_LOAD2: begin
        // Memory data is valid now; keep the address on the ALU and write Rt.
        sa     = dec_word[9:5];
        fs     = FS_ADD;
        bsel   = 1'b1;
        k      = sext_imm9(dec_word[20:12]);
        da     = dec_word[4:0];
        en_mem = 1'b1;
        wr     = 1'b1;
        ps     = PS_INC;
      end
      ST_BL2: begin
        k  = br_off26(dec_word[25:0]);
        ps = PS_REL;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  assign control_word = {en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr,
                         ps, fs, sb, sa, da};
  assign constant     = k;

endmodule

// File: tb/tb_legv8_control_unit.sv
// tb_legv8_control_unit
// Directed, table-driven bench for legv8_control_unit: single-state
// instructions are applied from a vector table in EXEC, and the multi-cycle
// cases (reset bubble, LDUR, BL, reset abort, illegal trap, HALT) are
// hand-written sequences. Outputs are sampled on the falling edge or a few
// time units after the rising edge.

module tb_legv8_control_unit;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  stat;
    logic [29:0] cw;
    logic [63:0] k;
  } vec_t;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  localparam logic [31:0] W_ADDI = 32'h9100_2822; // ADDI X2,X1,#10
  localparam logic [31:0] W_ADD  = 32'h8B02_0023; // ADD X3,X1,X2
  localparam logic [31:0] W_LDUR = 32'hF85F_8083; // LDUR X3,[X4,#-8]
  localparam logic [31:0] W_BL   = 32'h9400_0004; // BL +16
  localparam logic [31:0] W_ILL  = 32'hFFFF_FFFF;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [29:0] control_word;
  logic [63:0] constant;
  logic        halted;

  int nvec;
  int nfail;
  vec_t vecs [20];

  legv8_control_unit #(.ISA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .constant     (constant),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [29:0] cw(
    input logic en_pc, input logic en_mem, input logic en_alu, input logic pcsel,
    input logic bsel, input logic sl, input logic wm, input logic wr,
    input logic [1:0] ps, input logic [4:0] fs, input logic [4:0] sb,
    input logic [4:0] sa, input logic [4:0] da);
    return {en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr, ps, fs, sb, sa, da};
  endfunction

  task automatic check(input string name, input logic [29:0] exp_cw,
                       input logic [63:0] exp_k, input logic exp_h);
    nvec++;
    if (control_word !== exp_cw || constant !== exp_k || halted !== exp_h) begin
      nfail++;
      $display("FAIL %s: got cw=%h k=%h halted=%b, expected cw=%h k=%h halted=%b",
               name, control_word, constant, halted, exp_cw, exp_k, exp_h);
    end
  endtask

  initial begin
    nvec = 0;
    nfail = 0;

    vecs[0]  = '{"addi",     W_ADDI,       5'b00000, cw(O,O,I,O,I,O,O,I,2'b01,5'b01000,5'd0,5'd1,5'd2),   64'd10};
    vecs[1]  = '{"add",      W_ADD,        5'b00000, cw(O,O,I,O,O,O,O,I,2'b01,5'b01000,5'd2,5'd1,5'd3),   64'd0};
    vecs[2]  = '{"subs",     32'hEB06_00A4, 5'b00000, cw(O,O,I,O,O,I,O,I,2'b01,5'b01011,5'd6,5'd5,5'd4),  64'd0};
    vecs[3]  = '{"eor",      32'hCA09_0107, 5'b00000, cw(O,O,I,O,O,O,O,I,2'b01,5'b01100,5'd9,5'd8,5'd7),  64'd0};
    vecs[4]  = '{"orri",     32'hB23F_FC41, 5'b00000, cw(O,O,I,O,I,O,O,I,2'b01,5'b00100,5'd0,5'd2,5'd1),  64'hFFF};
    vecs[5]  = '{"subi",     32'hD100_0421, 5'b00000, cw(O,O,I,O,I,O,O,I,2'b01,5'b01011,5'd0,5'd1,5'd1),  64'd1};
    vecs[6]  = '{"lsl",      32'hD360_FD6A, 5'b00000, cw(O,O,I,O,I,O,O,I,2'b01,5'b10000,5'd0,5'd11,5'd10), 64'd63};
    vecs[7]  = '{"movz",     32'hD2D7_DDE5, 5'b00000, cw(O,O,I,O,I,O,O,I,2'b01,5'b11000,5'd0,5'd0,5'd5),  64'h0000_BEEF_0000_0000};
    vecs[8]  = '{"stur",     32'hF81F_8083, 5'b00000, cw(O,O,O,O,I,O,I,O,2'b01,5'b01000,5'd3,5'd4,5'd0),  64'hFFFF_FFFF_FFFF_FFF8};
    vecs[9]  = '{"b",        32'h17FF_FFFF, 5'b00000, cw(O,O,O,O,O,O,O,O,2'b11,5'b00000,5'd0,5'd0,5'd0),  64'hFFFF_FFFF_FFFF_FFFC};
    vecs[10] = '{"br",       32'hD600_03C0, 5'b00000, cw(O,O,O,O,O,O,O,O,2'b10,5'b00000,5'd0,5'd30,5'd0), 64'd0};
    vecs[11] = '{"cbz_tk",   32'hB400_0045, 5'b00001, cw(O,O,O,O,O,O,O,O,2'b11,5'b11000,5'd5,5'd0,5'd0),  64'd8};
    vecs[12] = '{"cbz_nt",   32'hB400_0045, 5'b00000, cw(O,O,O,O,O,O,O,O,2'b01,5'b11000,5'd5,5'd0,5'd0),  64'd8};
    vecs[13] = '{"cbnz_tk",  32'hB5FF_FFE5, 5'b00000, cw(O,O,O,O,O,O,O,O,2'b11,5'b11000,5'd5,5'd0,5'd0),  64'hFFFF_FFFF_FFFF_FFFC};
    vecs[14] = '{"bgt_tk",   32'h5400_006C, 5'b00000, cw(O,O,O,O,O,O,O,O,2'b11,5'b00000,5'd0,5'd0,5'd0),  64'd12};
    vecs[15] = '{"beq_nt",   32'h5400_0060, 5'b00000, cw(O,O,O,O,O,O,O,O,2'b01,5'b00000,5'd0,5'd0,5'd0),  64'd12};
    vecs[16] = '{"blt_tk",   32'h5400_006B, 5'b00100, cw(O,O,O,O,O,O,O,O,2'b11,5'b00000,5'd0,5'd0,5'd0),  64'd12};
    vecs[17] = '{"bhi_nt",   32'h5400_0068, 5'b01010, cw(O,O,O,O,O,O,O,O,2'b01,5'b00000,5'd0,5'd0,5'd0),  64'd12};
    vecs[18] = '{"bal_tk",   32'h5400_006E, 5'b01010, cw(O,O,O,O,O,O,O,O,2'b11,5'b00000,5'd0,5'd0,5'd0),  64'd12};
    vecs[19] = '{"bge_tk",   32'h5400_006A, 5'b10100, cw(O,O,O,O,O,O,O,O,2'b11,5'b00000,5'd0,5'd0,5'd0),  64'd12};

    clock = 1'b0;
    reset = 1'b1;
    instruction = W_ADDI;
    status = 5'b00000;

    // Reset held for three cycles: outputs must be zero throughout.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("reset", 30'd0, 64'd0, 1'b0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("bubble", 30'd0, 64'd0, 1'b0);
    @(posedge clock);
    #1;

    // Single-state instructions from the table.
    for (int i = 0; i < 20; i++) begin
      instruction = vecs[i].instr;
      status = vecs[i].stat;
      @(negedge clock);
      check(vecs[i].name, vecs[i].cw, vecs[i].k, 1'b0);
      @(posedge clock);
      #1;
    end
    status = 5'b00000;

    // LDUR: address phase then write-back phase decoded from the latch.
    instruction = W_LDUR;
    @(negedge clock);
    check("ldur1", cw(O,O,O,O,I,O,O,O,2'b00,5'b01000,5'd0,5'd4,5'd0), 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    @(posedge clock);
    #1 instruction = W_ILL;
    @(negedge clock);
    check("ldur2", cw(O,I,O,O,I,O,O,I,2'b01,5'b01000,5'd0,5'd4,5'd3), 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    @(posedge clock);
    #1 instruction = W_ADDI;
    @(negedge clock);
    check("after_ldur", vecs[0].cw, 64'd10, 1'b0);
    @(posedge clock);

    // BL: link phase then branch phase decoded from the latch.
    #1 instruction = W_BL;
    @(negedge clock);
    check("bl1", cw(I,O,O,O,O,O,O,I,2'b00,5'b00000,5'd0,5'd0,5'd30), 64'd0, 1'b0);
    @(posedge clock);
    #1 instruction = W_ADD;
    @(negedge clock);
    check("bl2", cw(O,O,O,O,O,O,O,O,2'b11,5'b00000,5'd0,5'd0,5'd0), 64'd16, 1'b0);
    @(posedge clock);

    // Reset asserted in the middle of LOAD2 clears outputs immediately.
    #1 instruction = W_LDUR;
    @(posedge clock);
    #1;
    check("abort_pre", cw(O,I,O,O,I,O,O,I,2'b01,5'b01000,5'd0,5'd4,5'd3), 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("abort", 30'd0, 64'd0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    instruction = W_ILL;
    @(negedge clock);
    check("abort_bubble", 30'd0, 64'd0, 1'b0);
    @(posedge clock);
    #1;

    // Unrecognised opcode.
    @(negedge clock);
`ifdef CU_ILLEGAL_TRAP_EN
    check("illegal", 30'd0, 64'd0, 1'b0);
`else
    check("illegal", cw(O,O,O,O,O,O,O,O,2'b01,5'b00000,5'd0,5'd0,5'd0), 64'd0, 1'b0);
`endif
    @(posedge clock);
    #1;
    @(negedge clock);
`ifdef CU_ILLEGAL_TRAP_EN
    check("illegal_trap", 30'd0, 64'd0, 1'b1);
`else
    check("illegal_nop", cw(O,O,O,O,O,O,O,O,2'b01,5'b00000,5'd0,5'd0,5'd0), 64'd0, 1'b0);
`endif

    // HALT: the all-zero word stops the unit until reset.
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 instruction = 32'h0000_0000;
    @(negedge clock);
    check("halt_exec", 30'd0, 64'd0, 1'b0);
    @(posedge clock);
    #1 instruction = W_ADDI;
    @(negedge clock);
    check("halted", 30'd0, 64'd0, 1'b1);
    @(posedge clock);
    @(negedge clock);
    check("halt_stays", 30'd0, 64'd0, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("halt_reset", 30'd0, 64'd0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("after_halt", vecs[0].cw, 64'd10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
